// File: rtl/counter_pkg.sv
// Shared constants for the counter family.
// These give readable names to the direction and limit-policy control bits.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic LIM_WRAP = 1'b0;
  localparam logic LIM_SAT  = 1'b1;

endpackage

// File: rtl/mod_up_down_counter.sv
// Modulo up/down counter with parallel load, wrap/saturate policy at the limits,
// a registered wrap pulse and a sticky overflow flag.
module mod_up_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MOD_MAX   = 31,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] dout,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_up_down_counter: WIDTH must be in 2..32");
  end
  if (MOD_MAX < 1 || longint'(MOD_MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("mod_up_down_counter: MOD_MAX must be in 1..2**WIDTH-1");
  end
  if (RESET_VAL > MOD_MAX) begin : g_bad_rst
    $error("mod_up_down_counter: RESET_VAL must not exceed MOD_MAX");
  end

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero     = '0;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    dout_d = dout_q;
    wrap_d = 1'b0;
    // A limit event below forces ovf high, so set beats a same-edge clear.
    ovf_d  = ovf_q & ~clr_ovf;
    if (load) begin
      dout_d = (din > MaxVal) ? MaxVal : din;
    end else if (en) begin
      if (mode == DIR_UP) begin
        if (dout_q == MaxVal) begin
          ovf_d = 1'b1;
          if (sat == LIM_WRAP) begin
            dout_d = Zero;
            wrap_d = 1'b1;
          end
        end else begin
          dout_d = dout_q + One;
        end
      end else begin
        if (dout_q == Zero) begin
          ovf_d = 1'b1;
          if (sat == LIM_WRAP) begin
            dout_d = MaxVal;
            wrap_d = 1'b1;
          end
        end else begin
          dout_d = dout_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= ResetVal;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule
